mux1024_sel5: RTL and testbench
===============================

Name: mux1024_sel5

Overview:
- 32-to-1 multiplexer over 32-bit words: 1024 input bits, 5-bit select.
- Used in the pipelined MIPS datapath as the register-file read-port selector: picks one of 32 register words by register number.
- Output is registered: one clock, asynchronous active-low reset.

Parameters:
- WIDTH, 32, bit width of each data input and of the output. Valid range is 1 or more. Input count is fixed at 32 and select width is fixed at 5.

Ports:
- clk  input  1  rising-edge clock for the output register
- rst_n  input  1  asynchronous active-low reset; clears the output register
- MUXin0 .. MUXin31  input  WIDTH each  32 individual data inputs; MUXinK is selected when sel equals K
- sel  input  5  unsigned select index, 0 to 31
- MUX_out  output  WIDTH  registered selected word

Behaviour:
- Reset:
  - rst_n low forces MUX_out to all zeros immediately, with no clock needed, and holds it while low.
  - Reset asserted mid-operation overrides any pending capture.
- Capture:
  - On each rising clk edge with rst_n high, MUX_out <= MUXin[sel].
  - Latency is exactly 1 cycle from the sel or input change to MUX_out.
  - There is no enable; the register loads every cycle.
- Reset release:
  - The first rising edge after rst_n deasserts loads the currently selected input.
  - MUX_out reads 0 until that edge.
- Decode:
  - Full decode: all 32 sel codes, 0 through 31, are legal and each selects its own input. There is no aliasing and no out-of-range code.
  - sel = 31 selects MUXin31; there is no wrap and no default-to-zero for valid codes.
  - A sel containing X or Z values (simulation only) produces all zeros on the next edge.
  - Data passes through unmodified: no sign or zero extension and no arithmetic, all WIDTH bits are copied.
- Timing of changes:
  - Simultaneous change of sel and the inputs before an edge: the edge captures the new sel applied to the new inputs.
  - An input changing while it is not selected has no effect on MUX_out.
- Implementation:
  - Combinational select feeding a single WIDTH-bit flop bank.
  - No internal state other than MUX_out.

Test Plan:
1. Reset check: rst_n=0 with MUXin0=0x0 .. MUXin10=0xA, others 0, sel=3 -> MUX_out=0x00000000 without any clock edge.
2. Sweep: MUXinK=K for K=0..10, MUXin11..31=0; step sel 0..10, holding each value for several cycles -> MUX_out equals sel value (0x0 .. 0xA) one cycle after each change.
3. Upper indices: sel=11..31 with those inputs 0 -> MUX_out=0. Then set MUXin31=0xDEADBEEF, sel=31 -> MUX_out=0xDEADBEEF after 1 edge.
4. Isolation: sel=5, MUXin5=0x5; toggle MUXin6 between 0xFFFFFFFF and 0 every cycle -> MUX_out stays 0x00000005.
5. Async reset mid-stream: sel=9, MUX_out=0x9; pulse rst_n low between edges -> MUX_out=0 immediately. After release, the next edge gives MUX_out=0x9.
6. Back-to-back: change sel every cycle 2, 7, 0, 10 -> MUX_out sequence 0x2, 0x7, 0x0, 0xA with 1-cycle lag and no bubbles.

Source files
------------

// File: rtl/mux1024_sel5.sv
// ----------------------------------------------------------------------------
// mux1024_sel5
//
// Registered 32-to-1 word multiplexer. It serves as the register-file read-port
// selector in the pipelined MIPS datapath. A register number picks one of 32
// words, and the chosen word is registered. It appears on MUX_out one clock
// after sel or the data inputs change.
//
// Ports:
//   clk               rising-edge clock for the output register
//   rst_n             asynchronous active-low reset, clears MUX_out
//   MUXin0..MUXin31   WIDTH-bit data inputs; MUXinK is chosen when sel == K
//   sel               5-bit unsigned select index, 0..31 (every code is legal)
//   MUX_out           WIDTH-bit registered selected word
// ----------------------------------------------------------------------------
module mux1024_sel5 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] MUXin0,
    input  logic [WIDTH-1:0] MUXin1,
    input  logic [WIDTH-1:0] MUXin2,
    input  logic [WIDTH-1:0] MUXin3,
    input  logic [WIDTH-1:0] MUXin4,
    input  logic [WIDTH-1:0] MUXin5,
    input  logic [WIDTH-1:0] MUXin6,
    input  logic [WIDTH-1:0] MUXin7,
    input  logic [WIDTH-1:0] MUXin8,
    input  logic [WIDTH-1:0] MUXin9,
    input  logic [WIDTH-1:0] MUXin10,
    input  logic [WIDTH-1:0] MUXin11,
    input  logic [WIDTH-1:0] MUXin12,
    input  logic [WIDTH-1:0] MUXin13,
    input  logic [WIDTH-1:0] MUXin14,
    input  logic [WIDTH-1:0] MUXin15,
    input  logic [WIDTH-1:0] MUXin16,
    input  logic [WIDTH-1:0] MUXin17,
    input  logic [WIDTH-1:0] MUXin18,
    input  logic [WIDTH-1:0] MUXin19,
    input  logic [WIDTH-1:0] MUXin20,
    input  logic [WIDTH-1:0] MUXin21,
    input  logic [WIDTH-1:0] MUXin22,
    input  logic [WIDTH-1:0] MUXin23,
    input  logic [WIDTH-1:0] MUXin24,
    input  logic [WIDTH-1:0] MUXin25,
    input  logic [WIDTH-1:0] MUXin26,
    input  logic [WIDTH-1:0] MUXin27,
    input  logic [WIDTH-1:0] MUXin28,
    input  logic [WIDTH-1:0] MUXin29,
    input  logic [WIDTH-1:0] MUXin30,
    input  logic [WIDTH-1:0] MUXin31,
    input  logic [4:0]       sel,
    output logic [WIDTH-1:0] MUX_out
);

    // Gather the individual ports into an indexable array so the select
    // logic is a single expression rather than 32 hand-written arms.
    logic [WIDTH-1:0] words [32];

    assign words[0]  = MUXin0;
    assign words[1]  = MUXin1;
    assign words[2]  = MUXin2;
    assign words[3]  = MUXin3;
    assign words[4]  = MUXin4;
    assign words[5]  = MUXin5;
    assign words[6]  = MUXin6;
    assign words[7]  = MUXin7;
    assign words[8]  = MUXin8;
    assign words[9]  = MUXin9;
    assign words[10] = MUXin10;
    assign words[11] = MUXin11;
    assign words[12] = MUXin12;
    assign words[13] = MUXin13;
    assign words[14] = MUXin14;
    assign words[15] = MUXin15;
    assign words[16] = MUXin16;
    assign words[17] = MUXin17;
    assign words[18] = MUXin18;
    assign words[19] = MUXin19;
    assign words[20] = MUXin20;
    assign words[21] = MUXin21;
    assign words[22] = MUXin22;
    assign words[23] = MUXin23;
    assign words[24] = MUXin24;
    assign words[25] = MUXin25;
    assign words[26] = MUXin26;
    assign words[27] = MUXin27;
    assign words[28] = MUXin28;
    assign words[29] = MUXin29;
    assign words[30] = MUXin30;
    assign words[31] = MUXin31;

    logic [WIDTH-1:0] selected;

    // An equality compare per code gives a full one-hot decode. A sel carrying
    // X or Z matches no code, so the zero default is captured in that case.
    always_comb begin
        // NOTE: default assignment first so every path writes selected; without it this block infers a latch.
        selected = '0;
        for (int k = 0; k < 32; k++) begin
            if (sel == 5'(k)) begin
                selected = words[k];
            end
        end
    end

    // Single WIDTH-bit output register, loaded every cycle (no enable).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
            MUX_out <= '0;
        end else begin
            MUX_out <= selected;
        end
    end

endmodule

// File: tb/tb_mux1024_sel5.sv
// ----------------------------------------------------------------------------
// tb_mux1024_sel5
//
// Self-checking bench for mux1024_sel5. The reference model treats the inputs
// as a plain array. At every rising edge the expected output becomes the
// element the select index points at, and it becomes zero while reset is low.
// ----------------------------------------------------------------------------
module tb_mux1024_sel5;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din [32];
    logic [4:0]       sel;
    logic [WIDTH-1:0] MUX_out;

    int n_checks;
    int n_pass;
    logic [WIDTH-1:0] exp_out;

    mux1024_sel5 #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .MUXin0  (din[0]),
        .MUXin1  (din[1]),
        .MUXin2  (din[2]),
        .MUXin3  (din[3]),
        .MUXin4  (din[4]),
        .MUXin5  (din[5]),
        .MUXin6  (din[6]),
        .MUXin7  (din[7]),
        .MUXin8  (din[8]),
        .MUXin9  (din[9]),
        .MUXin10 (din[10]),
        .MUXin11 (din[11]),
        .MUXin12 (din[12]),
        .MUXin13 (din[13]),
        .MUXin14 (din[14]),
        .MUXin15 (din[15]),
        .MUXin16 (din[16]),
        .MUXin17 (din[17]),
        .MUXin18 (din[18]),
        .MUXin19 (din[19]),
        .MUXin20 (din[20]),
        .MUXin21 (din[21]),
        .MUXin22 (din[22]),
        .MUXin23 (din[23]),
        .MUXin24 (din[24]),
        .MUXin25 (din[25]),
        .MUXin26 (din[26]),
        .MUXin27 (din[27]),
        .MUXin28 (din[28]),
        .MUXin29 (din[29]),
        .MUXin30 (din[30]),
        .MUXin31 (din[31]),
        .sel     (sel),
        .MUX_out (MUX_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load the inputs with MUXinK = K for K = 0..10 and zeros elsewhere.
    task automatic load_ramp();
        for (int k = 0; k < 32; k++) din[k] = (k <= 10) ? WIDTH'(k) : '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_ramp();
        sel = 5'd3;
        #2;
        n_checks++;
        if (MUX_out !== '0) $display("FAIL reset_no_clock: got %h want %h", MUX_out, 32'h0);
        else n_pass++;
        tick();
        n_checks++;
        if (MUX_out !== '0) $display("FAIL reset_held_over_edge: got %h want %h", MUX_out, 32'h0);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (MUX_out !== '0) $display("FAIL reset_release_before_edge: got %h want %h", MUX_out, 32'h0);
        else n_pass++;
        exp_out = din[sel];
        tick();
        n_checks++;
        if (MUX_out !== exp_out) $display("FAIL reset_release_first_edge: got %h want %h", MUX_out, exp_out);
        else n_pass++;
    endtask

    task automatic test_sweep();
        load_ramp();
        for (int s = 0; s <= 10; s++) begin
            sel = 5'(s);
            exp_out = din[s];
            for (int c = 0; c < 3; c++) begin
                tick();
                n_checks++;
                if (MUX_out !== exp_out) $display("FAIL sweep sel=%0d cyc=%0d: got %h want %h", s, c, MUX_out, exp_out);
                else n_pass++;
            end
        end
    endtask

    task automatic test_upper();
        load_ramp();
        for (int s = 11; s < 32; s++) begin
            sel = 5'(s);
            exp_out = din[s];
            tick();
            n_checks++;
            if (MUX_out !== exp_out) $display("FAIL upper_zero sel=%0d: got %h want %h", s, MUX_out, exp_out);
            else n_pass++;
        end
        din[31] = 32'hDEAD_BEEF;
        sel = 5'd31;
        exp_out = 32'hDEAD_BEEF;
        tick();
        n_checks++;
        if (MUX_out !== exp_out) $display("FAIL upper_sel31: got %h want %h", MUX_out, exp_out);
        else n_pass++;
    endtask

    task automatic test_isolation();
        load_ramp();
        sel = 5'd5;
        exp_out = 32'h0000_0005;
        for (int c = 0; c < 8; c++) begin
            din[6] = (c % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
            tick();
            n_checks++;
            if (MUX_out !== exp_out) $display("FAIL isolation cyc=%0d: got %h want %h", c, MUX_out, exp_out);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        load_ramp();
        sel = 5'd9;
        tick();
        n_checks++;
        if (MUX_out !== 32'h9) $display("FAIL async_pre: got %h want %h", MUX_out, 32'h9);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (MUX_out !== '0) $display("FAIL async_immediate: got %h want %h", MUX_out, 32'h0);
        else n_pass++;
        rst_n = 1'b1;
        #0.5;
        n_checks++;
        if (MUX_out !== '0) $display("FAIL async_after_release: got %h want %h", MUX_out, 32'h0);
        else n_pass++;
        tick();
        n_checks++;
        if (MUX_out !== 32'h9) $display("FAIL async_recover: got %h want %h", MUX_out, 32'h9);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] seq [4];
        seq[0] = 5'd2; seq[1] = 5'd7; seq[2] = 5'd0; seq[3] = 5'd10;
        load_ramp();
        for (int i = 0; i < 4; i++) begin
            // The output must still hold the previous capture right after sel moves.
            logic [WIDTH-1:0] prev;
            prev = MUX_out;
            sel = seq[i];
            exp_out = din[seq[i]];
            #1;
            n_checks++;
            if (MUX_out !== prev) $display("FAIL b2b_hold step=%0d: got %h want %h", i, MUX_out, prev);
            else n_pass++;
            tick();
            n_checks++;
            if (MUX_out !== exp_out) $display("FAIL b2b step=%0d: got %h want %h", i, MUX_out, exp_out);
            else n_pass++;
        end
    endtask

    // Random words and select each cycle; inputs and sel change together.
    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 32; k++) din[k] = $urandom();
            sel = 5'($urandom_range(0, 31));
            exp_out = din[sel];
            tick();
            n_checks++;
            if (MUX_out !== exp_out) $display("FAIL random cyc=%0d sel=%0d: got %h want %h", c, sel, MUX_out, exp_out);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_sweep();
        test_upper();
        test_isolation();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
